// File: rtl/cb_pkg.sv
// Shared types for the crossbar egress/ingress stages: handshake FSM states,
// storage word/pointer types and the FIFO depth helper.
package cb_pkg;
   localparam int CB_DWIDTH = 32;
   localparam int CB_BWIDTH = 3;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } fsm_state_t;

   typedef logic [CB_BWIDTH-1:0] ptr_t;
   typedef logic [CB_DWIDTH-1:0] buff_t;

   function automatic int unsigned cb_depth(input int unsigned bwidth);
      return 32'd1 << bwidth;
   endfunction
endpackage

// File: rtl/cb_fifo.sv
// First-word fall-through FIFO with a level register driving full/empty.
// Storage is not reset; only pointers and level are cleared.
module cb_fifo
   import cb_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int BWIDTH = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [DWIDTH-1:0] pop_data,
   output logic [BWIDTH:0]   level,
   output logic              full,
   output logic              empty
);
   localparam int             DEPTH     = cb_depth(BWIDTH);
   localparam logic [BWIDTH:0] DEPTH_LVL = (BWIDTH+1)'(DEPTH);

   logic [DWIDTH-1:0] buff [DEPTH];
   logic [BWIDTH-1:0] wr_ptr;
   logic [BWIDTH-1:0] rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   // Guard both sides so a misbehaving caller cannot over- or under-run the level.
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign full     = (level == DEPTH_LVL);
   assign empty    = (level == '0);
   assign pop_data = buff[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         buff[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/cb_egress.sv
// Crossbar output stage: accepts words over req/resp, buffers them, and
// re-issues them to the sink on valid/ready while counting deliveries.
//
// state | meaning
// IDLE  | waiting for in_req with space available; accepts and pulses in_resp
// ACK   | guard cycle after an accept; crossbar drops req or changes data
module cb_egress
   import cb_pkg::*;
#(
   parameter int DWIDTH    = 32,
   parameter int BWIDTH    = 3,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [DWIDTH-1:0]    in_data,
   input  logic                 in_req,
   output logic                 in_resp,
   output logic [DWIDTH-1:0]    out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BWIDTH:0]      level,
   output logic                 full,
   output logic                 empty,
   output logic [CNT_WIDTH-1:0] xfer_cnt
);
   fsm_state_t state;
   fsm_state_t state_nxt;
   logic       push;
   logic       pop;

   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;

   cb_fifo #(
      .DWIDTH (DWIDTH),
      .BWIDTH (BWIDTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (out_data),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         in_resp <= 1'b0;
      end else begin
         state   <= state_nxt;
         in_resp <= push;
      end
   end

   // full is the pre-edge value, so a pop on the decision edge does not unblock this push.
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (in_req && !full) begin
               push      = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         xfer_cnt <= '0;
      end else if (pop) begin
         xfer_cnt <= xfer_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_cb_egress.sv
// Self-checking bench for cb_egress: randomized traffic against a queue-based
// reference model of the accept/deliver rules.
module tb_cb_egress;
   localparam int DW    = 32;
   localparam int BW    = 3;
   localparam int CW    = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] in_data;
   logic          in_req;
   logic          in_resp;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [BW:0]   level;
   logic          full;
   logic          empty;
   logic [CW-1:0] xfer_cnt;

   int checks   = 0;
   int failures = 0;

   // reference model: buffered words, "accepted last cycle" flag, expected resp and count
   logic [DW-1:0] m_q [$];
   bit            m_ack;
   bit            m_resp;
   logic [CW-1:0] m_cnt;

   logic [DW-1:0] src  [$];
   logic [DW-1:0] sent [$];
   logic [DW-1:0] del  [$];
   int            rdy_mode;
   int            resp_seen;

   cb_egress #(.DWIDTH(DW), .BWIDTH(BW), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_data   (in_data),
      .in_req    (in_req),
      .in_resp   (in_resp),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .full      (full),
      .empty     (empty),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive();
      in_req  = (src.size() > 0);
      in_data = in_req ? src[0] : DW'($urandom());
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic tick();
      if (rstn && out_valid && out_ready) del.push_back(out_data);
      @(posedge clk);
      if (!rstn) begin
         m_q.delete();
         m_ack  = 1'b0;
         m_resp = 1'b0;
         m_cnt  = '0;
      end else begin
         bit pop_m;
         bit push_m;
         pop_m  = (m_q.size() > 0) && out_ready;
         push_m = !m_ack && in_req && (m_q.size() < DEPTH);
         if (pop_m) begin
            void'(m_q.pop_front());
            m_cnt = m_cnt + 1'b1;
         end
         if (push_m) m_q.push_back(in_data);
         m_ack  = push_m;
         m_resp = push_m;
      end
      @(negedge clk);
      if (in_resp) begin
         resp_seen++;
         if (src.size() > 0) void'(src.pop_front());
      end
      drive();
   endtask

   task automatic test_reset();
      rstn     = 1'b0;
      rdy_mode = 1;
      src.push_back(32'hA5A5_0000);
      drive();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (in_resp !== 1'b0) begin failures++; $display("FAIL reset_resp cyc=%0d got=%b exp=0", i, in_resp); end
         checks++; if (level !== '0) begin failures++; $display("FAIL reset_level cyc=%0d got=%0d exp=0", i, level); end
         checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty cyc=%0d got=%b exp=1", i, empty); end
         checks++; if (xfer_cnt !== '0) begin failures++; $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", i, xfer_cnt); end
      end
      src.delete();
      rstn = 1'b1;
      drive();
   endtask

   task automatic test_single();
      rdy_mode = 0;
      src.push_back(32'hDEADBEEF);
      drive();
      tick();
      checks++; if (in_resp !== 1'b1) begin failures++; $display("FAIL single_resp got=%b exp=1", in_resp); end
      tick();
      checks++; if (in_resp !== 1'b0) begin failures++; $display("FAIL single_resp_pulse got=%b exp=0", in_resp); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", out_data); end
      checks++; if (level !== 4'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
      rdy_mode = 1;
      drive();
      tick();
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
      checks++; if (xfer_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", xfer_cnt); end
   endtask

   task automatic test_fill();
      int t;
      rdy_mode  = 0;
      resp_seen = 0;
      for (int i = 0; i < 10; i++) src.push_back(DW'(i));
      drive();
      repeat (30) tick();
      checks++; if (resp_seen != 8) begin failures++; $display("FAIL fill_resp_count got=%0d exp=8", resp_seen); end
      checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
      checks++; if (level !== 4'd8) begin failures++; $display("FAIL fill_level got=%0d exp=8", level); end
      checks++; if (in_resp !== 1'b0 || in_req !== 1'b1) begin failures++; $display("FAIL fill_stall resp=%b req=%b exp resp=0 req=1", in_resp, in_req); end
      del.delete();
      rdy_mode = 1;
      drive();
      t = 0;
      while (t < 80 && !(src.size() == 0 && m_q.size() == 0 && out_valid === 1'b0)) begin
         tick();
         t++;
      end
      checks++; if (t >= 80) begin failures++; $display("FAIL fill_drain_timeout got=%0d cycles exp<80", t); end
      checks++; if (del.size() != 10) begin failures++; $display("FAIL fill_drain_count got=%0d exp=10", del.size()); end
      for (int i = 0; i < del.size() && i < 10; i++) begin
         checks++; if (del[i] !== DW'(i)) begin failures++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, del[i], i); end
      end
      checks++; if (xfer_cnt !== m_cnt) begin failures++; $display("FAIL fill_cnt got=%0d exp=%0d", xfer_cnt, m_cnt); end
   endtask

   task automatic test_wrap();
      int            t;
      int            max_lvl;
      logic [CW-1:0] cnt0;
      rdy_mode = 1;
      sent.delete();
      del.delete();
      for (int i = 0; i < 20; i++) begin
         logic [DW-1:0] w;
         w = DW'($urandom());
         sent.push_back(w);
         src.push_back(w);
      end
      cnt0 = xfer_cnt;
      max_lvl = 0;
      drive();
      t = 0;
      while (t < 200 && del.size() < 20) begin
         tick();
         if (int'(level) > max_lvl) max_lvl = int'(level);
         t++;
      end
      checks++; if (t >= 200) begin failures++; $display("FAIL wrap_timeout got=%0d cycles exp<200", t); end
      checks++; if (max_lvl > 1) begin failures++; $display("FAIL wrap_max_level got=%0d exp<=1", max_lvl); end
      checks++; if (CW'(xfer_cnt - cnt0) !== CW'(20)) begin failures++; $display("FAIL wrap_cnt got=%0d exp=20", CW'(xfer_cnt - cnt0)); end
      for (int i = 0; i < del.size() && i < 20; i++) begin
         checks++; if (del[i] !== sent[i]) begin failures++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, del[i], sent[i]); end
      end
   endtask

   task automatic test_back_pressure();
      int t;
      rdy_mode = 2;
      sent.delete();
      del.delete();
      for (int i = 0; i < 100; i++) begin
         logic [DW-1:0] w;
         w = DW'($urandom());
         sent.push_back(w);
         src.push_back(w);
      end
      drive();
      t = 0;
      while (t < 3000 && del.size() < 100) begin
         tick();
         t++;
         checks++; if (level !== (BW+1)'(m_q.size())) begin failures++; $display("FAIL bp_level t=%0d got=%0d exp=%0d", t, level, m_q.size()); end
         checks++; if (in_resp !== m_resp) begin failures++; $display("FAIL bp_resp t=%0d got=%b exp=%b", t, in_resp, m_resp); end
         checks++; if (out_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL bp_valid t=%0d got=%b exp=%b", t, out_valid, m_q.size() > 0); end
         checks++; if (full !== (m_q.size() == DEPTH)) begin failures++; $display("FAIL bp_full t=%0d got=%b exp=%b", t, full, m_q.size() == DEPTH); end
         if (m_q.size() > 0) begin
            checks++; if (out_data !== m_q[0]) begin failures++; $display("FAIL bp_data t=%0d got=%h exp=%h", t, out_data, m_q[0]); end
         end
      end
      checks++; if (t >= 3000) begin failures++; $display("FAIL bp_timeout got=%0d cycles exp<3000", t); end
      for (int i = 0; i < del.size() && i < 100; i++) begin
         checks++; if (del[i] !== sent[i]) begin failures++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, del[i], sent[i]); end
      end
      checks++; if (xfer_cnt !== m_cnt) begin failures++; $display("FAIL bp_cnt got=%0d exp=%0d", xfer_cnt, m_cnt); end
   endtask

   task automatic test_reset_mid();
      int t;
      rdy_mode = 0;
      for (int i = 0; i < 5; i++) src.push_back(DW'(32'h5000 + i));
      drive();
      t = 0;
      while (t < 40 && m_q.size() < 5) begin
         tick();
         t++;
      end
      checks++; if (level !== 4'd5) begin failures++; $display("FAIL mid_level_before got=%0d exp=5", level); end
      src.delete();
      rstn = 1'b0;
      drive();
      tick();
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_empty got=%b exp=1", empty); end
      checks++; if (xfer_cnt !== '0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", xfer_cnt); end
      checks++; if (in_resp !== 1'b0) begin failures++; $display("FAIL mid_resp got=%b exp=0", in_resp); end
      rstn = 1'b1;
      del.delete();
      src.push_back(32'h0000_1234);
      rdy_mode = 1;
      drive();
      t = 0;
      while (t < 20 && del.size() == 0) begin
         tick();
         t++;
      end
      checks++; if (del.size() == 0) begin failures++; $display("FAIL mid_post_timeout got=none exp=00001234"); end
      else begin
         checks++; if (del[0] !== 32'h0000_1234) begin failures++; $display("FAIL mid_first_word got=%h exp=00001234", del[0]); end
      end
   endtask

   initial begin
      m_ack  = 1'b0;
      m_resp = 1'b0;
      m_cnt  = '0;
      test_reset();
      test_single();
      test_fill();
      test_wrap();
      test_back_pressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
